// File: rtl/wash_pkg.sv
// wash_pkg: constants shared by the wash-machine panel and controller.
//   - bus_in bit positions (BI_*)
//   - one-hot temperature encodings (TEMP_*)
package wash_pkg;

  localparam int BI_EMPTY   = 0;
  localparam int BI_FULL    = 1;
  localparam int BI_CLOCK   = 2;
  localparam int BI_XRINSE  = 3;
  localparam int BI_HOT     = 4;
  localparam int BI_WARM    = 5;
  localparam int BI_COLD    = 6;
  localparam int BI_RESTART = 7;
  localparam int BI_START   = 8;

  localparam logic [2:0] TEMP_HOT  = 3'b001;
  localparam logic [2:0] TEMP_WARM = 3'b010;
  localparam logic [2:0] TEMP_COLD = 3'b100;

endpackage

// File: rtl/panel_debounce.sv
// panel_debounce: 2-flop synchroniser followed by a counting debouncer.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   i_raw          raw asynchronous input
//   o_level        accepted (debounced) level, 0 after reset
//   o_rise         high in the cycle whose closing edge takes o_level 0->1
module panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_hit;

  assign w_diff = r_sync[1] ^ r_level;
  assign w_hit  = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (w_diff) begin
        if (w_hit) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  // Strobe in the same cycle the flip is committed so downstream flags
  // register together with the new level.
  assign o_rise  = w_diff & w_hit & ~r_level;

endmodule

// File: rtl/wash_panel_input.sv
// wash_panel_input: conditions the front-panel buttons and float switches
// into the 9-bit bus_in word read by wash_control.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   btn_start/restart   raw start / restart buttons
//   btn_extra_rinse     raw extra-rinse toggle button
//   btn_temp[2:0]       raw {cold,warm,hot} buttons
//   sw_low, sw_high     raw float switches
//   busy                cycle running; locks temperature and extra-rinse
//   bus_in[8:0]         {start,restart,cold,warm,hot,xrinse,clock,full,empty}
//   level_fault         high switch made without low switch
module wash_panel_input
  import wash_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_restart,
  input  logic       btn_extra_rinse,
  input  logic [2:0] btn_temp,
  input  logic       sw_low,
  input  logic       sw_high,
  input  logic       busy,
  output logic [8:0] bus_in,
  output logic       level_fault
);

  localparam int TCW  = $clog2(TICK_DIV);
  localparam int HALF = TICK_DIV / 2;

  // Debouncer slots: 0 start, 1 restart, 2 extra rinse, 3 hot, 4 warm,
  // 5 cold, 6 low switch, 7 high switch.
  logic [7:0] w_raw;
  logic [7:0] w_level;
  logic [7:0] w_rise;

  assign w_raw = {sw_high, sw_low, btn_temp, btn_extra_rinse, btn_restart, btn_start};

  for (genvar g = 0; g < 8; g++) begin : g_deb
    panel_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset  (reset),
      .i_raw  (w_raw[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g])
    );
  end

  logic           r_tclk;
  logic [TCW-1:0] r_tcnt;
  logic           w_tick_rise;
  logic           r_start_req;
  logic           r_start_seen;
  logic           r_restart_req;
  logic           r_restart_seen;
  logic [2:0]     r_temp;
  logic           r_xrinse;

  // Tick fires on the edge where the count wraps back to 0.
  assign w_tick_rise = (r_tcnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tcnt <= '0;
      r_tclk <= 1'b0;
    end else begin
      r_tcnt <= w_tick_rise ? '0 : r_tcnt + 1'b1;
      r_tclk <= (r_tcnt < TCW'(HALF));
    end
  end

  // Requests stay up until the second tick after they were set, so the
  // slow timer domain is guaranteed one full period to sample them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_start_req    <= 1'b0;
      r_start_seen   <= 1'b0;
      r_restart_req  <= 1'b0;
      r_restart_seen <= 1'b0;
    end else begin
      if (w_rise[1]) begin
        r_start_req  <= 1'b0;
        r_start_seen <= 1'b0;
      end else if (w_rise[0] && !r_start_req) begin
        r_start_req  <= 1'b1;
        r_start_seen <= 1'b0;
      end else if (r_start_req && w_tick_rise) begin
        if (r_start_seen) r_start_req <= 1'b0;
        else              r_start_seen <= 1'b1;
      end

      if (w_rise[1] && !r_restart_req) begin
        r_restart_req  <= 1'b1;
        r_restart_seen <= 1'b0;
      end else if (r_restart_req && w_tick_rise) begin
        if (r_restart_seen) r_restart_req <= 1'b0;
        else                r_restart_seen <= 1'b1;
      end
    end
  end

  // Selections: restart overrides everything; otherwise only idle edges count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_temp   <= TEMP_WARM;
      r_xrinse <= 1'b0;
    end else if (w_rise[1]) begin
      r_temp   <= TEMP_WARM;
      r_xrinse <= 1'b0;
    end else if (!busy) begin
      if (w_rise[5])      r_temp <= TEMP_COLD;
      else if (w_rise[4]) r_temp <= TEMP_WARM;
      else if (w_rise[3]) r_temp <= TEMP_HOT;
      if (w_rise[2]) r_xrinse <= ~r_xrinse;
    end
  end

  always_comb begin
    bus_in              = '0;
    bus_in[BI_START]    = r_start_req;
    bus_in[BI_RESTART]  = r_restart_req;
    bus_in[BI_COLD]     = r_temp[2];
    bus_in[BI_WARM]     = r_temp[1];
    bus_in[BI_HOT]      = r_temp[0];
    bus_in[BI_XRINSE]   = r_xrinse;
    bus_in[BI_CLOCK]    = r_tclk;
    bus_in[BI_FULL]     = w_level[7] & w_level[6];
    bus_in[BI_EMPTY]    = ~w_level[7] & ~w_level[6];
  end

  assign level_fault = w_level[7] & ~w_level[6];

endmodule
